// File: rtl/spi_peripheral_generic.sv
// SPI target endpoint: oversampled pins, all four CPOL/CPHA modes, 1..Max_Bit_Width frames,
// a persistent tx buffer loaded by req/ack, and an rx frame handed off by req/ack.
module spi_peripheral_generic #(
    parameter int Max_Bit_Width   = 32,
    parameter int Sync_Stages     = 2,
    parameter int Bit_Index_Width = $clog2(Max_Bit_Width) + 1
) (
    input  logic                       clk,
    input  logic                       clk_en,
    input  logic                       sync_rst,
    input  logic                       cfg_cpol,
    input  logic                       cfg_cpha,
    input  logic [Bit_Index_Width-1:0] cfg_width,
    input  logic [Max_Bit_Width-1:0]   tx_data,
    input  logic                       tx_load_req,
    output logic                       tx_load_ack,
    output logic                       rx_data_req,
    input  logic                       rx_data_ack,
    output logic [Max_Bit_Width-1:0]   rx_data,
    output logic                       rx_overrun,
    output logic                       frame_abort,
    input  logic                       sclk,
    input  logic                       cs_n,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_en
);

    localparam logic [Bit_Index_Width-1:0] MAXW = Bit_Index_Width'(Max_Bit_Width);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [Sync_Stages-1:0]     r_sclk_sync;
    logic [Sync_Stages-1:0]     r_cs_sync;
    logic [Sync_Stages-1:0]     r_copi_sync;
    logic                       r_sclk_prev;
    logic                       r_cs_prev;

    logic                       r_cpol;
    logic                       r_cpha;
    logic [Bit_Index_Width-1:0] r_width;
    logic [Bit_Index_Width-1:0] r_cnt;
    logic [Max_Bit_Width-1:0]   r_tx_buf;
    logic [Max_Bit_Width-1:0]   r_tx_shift;
    logic [Max_Bit_Width-1:0]   r_rx_shift;
    logic                       r_cipo;
    logic [Max_Bit_Width-1:0]   r_rx_data;
    logic                       r_rx_req;
    logic                       r_overrun;
    logic                       r_abort;

    logic                       w_sclk;
    logic                       w_cs;
    logic                       w_copi;
    logic                       w_lead;
    logic                       w_trail;
    logic                       w_sample;
    logic                       w_drive;
    logic                       w_cs_fall;
    logic                       w_cs_rise;
    logic [Bit_Index_Width-1:0] w_width_eff;
    logic [Bit_Index_Width-1:0] w_shamt;
    logic [Max_Bit_Width-1:0]   w_tx_aligned;
    logic [Max_Bit_Width-1:0]   w_rx_next;
    logic [Bit_Index_Width-1:0] w_cnt_next;
    logic                       w_last;
    logic                       w_deliver;

    assign w_sclk    = r_sclk_sync[Sync_Stages-1];
    assign w_cs      = r_cs_sync[Sync_Stages-1];
    assign w_copi    = r_copi_sync[Sync_Stages-1];
    assign w_lead    = (r_sclk_prev == r_cpol) && (w_sclk != r_cpol);
    assign w_trail   = (r_sclk_prev != r_cpol) && (w_sclk == r_cpol);
    assign w_sample  = r_cpha ? w_trail : w_lead;
    assign w_drive   = r_cpha ? w_lead : w_trail;
    assign w_cs_fall = r_cs_prev && !w_cs;
    assign w_cs_rise = !r_cs_prev && w_cs;

    // The tx word is left-aligned at frame start so bit width-1 always leaves from the MSB.
    assign w_width_eff  = ((cfg_width == '0) || (cfg_width > MAXW)) ? MAXW : cfg_width;
    assign w_shamt      = MAXW - w_width_eff;
    assign w_tx_aligned = r_tx_buf << w_shamt;
    assign w_rx_next    = (r_rx_shift << 1) | Max_Bit_Width'(w_copi);
    assign w_cnt_next   = r_cnt + 1'b1;
    assign w_last       = w_sample && (w_cnt_next == r_width);
    assign w_deliver    = (r_state == ACTIVE) && !w_cs_rise && w_last;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_copi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
            r_state     <= IDLE;
        end else if (clk_en) begin
            r_sclk_sync <= {r_sclk_sync[Sync_Stages-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[Sync_Stages-2:0], cs_n};
            r_copi_sync <= {r_copi_sync[Sync_Stages-2:0], copi};
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs;
            r_state     <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_cs_fall) w_state_next = ACTIVE;
            ACTIVE: begin
                if (w_cs_rise)   w_state_next = IDLE;
                else if (w_last) w_state_next = COMPLETE;
            end
            COMPLETE: if (w_cs_rise) w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_comb begin
        cipo_en     = (r_state != IDLE);
        cipo        = (r_state != IDLE) && r_cipo;
        tx_load_ack = tx_load_req && clk_en && (r_state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_width    <= '0;
            r_cnt      <= '0;
            r_tx_buf   <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_cipo     <= 1'b0;
            r_abort    <= 1'b0;
        end else if (clk_en) begin
            r_abort <= 1'b0;
            if (tx_load_ack) r_tx_buf <= tx_data;
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_cpol     <= cfg_cpol;
                        r_cpha     <= cfg_cpha;
                        r_width    <= w_width_eff;
                        r_cnt      <= '0;
                        r_rx_shift <= '0;
                        // cpha=0 must present the first bit before any clock edge arrives.
                        if (!cfg_cpha) begin
                            r_cipo     <= w_tx_aligned[Max_Bit_Width-1];
                            r_tx_shift <= w_tx_aligned << 1;
                        end else begin
                            r_cipo     <= 1'b0;
                            r_tx_shift <= w_tx_aligned;
                        end
                    end
                end
                ACTIVE: begin
                    if (w_cs_rise) begin
                        r_abort    <= 1'b1;
                        r_rx_shift <= '0;
                    end else begin
                        if (w_drive) begin
                            r_cipo     <= r_tx_shift[Max_Bit_Width-1];
                            r_tx_shift <= r_tx_shift << 1;
                        end
                        if (w_sample) begin
                            r_rx_shift <= w_rx_next;
                            r_cnt      <= w_cnt_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // An ack in the delivery cycle frees the slot for the new frame, so it is not an overrun.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_rx_data <= '0;
            r_rx_req  <= 1'b0;
            r_overrun <= 1'b0;
        end else if (clk_en) begin
            r_overrun <= 1'b0;
            if (w_deliver) begin
                if (!r_rx_req || rx_data_ack) begin
                    r_rx_data <= w_rx_next;
                    r_rx_req  <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (rx_data_ack) begin
                r_rx_req <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_data_req = r_rx_req;
    assign rx_overrun  = r_overrun;
    assign frame_abort = r_abort;

endmodule

// File: tb/tb_spi_peripheral_generic.sv
// Directed bench: acts as the SPI controller, checks a vector table of full frames,
// then abort, overrun, deferred tx load and mid-frame reset sequences.
module tb_spi_peripheral_generic;

    localparam int HALF = 10;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        sync_rst = 1'b1;
    logic        cfg_cpol = 1'b0;
    logic        cfg_cpha = 1'b0;
    logic [5:0]  cfg_width = 6'd8;
    logic [31:0] tx_data = '0;
    logic        tx_load_req = 1'b0;
    logic        tx_load_ack;
    logic        rx_data_req;
    logic        rx_data_ack = 1'b0;
    logic [31:0] rx_data;
    logic        rx_overrun;
    logic        frame_abort;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        copi = 1'b0;
    logic        cipo;
    logic        cipo_en;

    int n_vec = 0;
    int n_err = 0;
    int n_abort = 0;
    int n_ovr = 0;

    spi_peripheral_generic #(.Max_Bit_Width(32), .Sync_Stages(SYNC)) dut (
        .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst),
        .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_width(cfg_width),
        .tx_data(tx_data), .tx_load_req(tx_load_req), .tx_load_ack(tx_load_ack),
        .rx_data_req(rx_data_req), .rx_data_ack(rx_data_ack), .rx_data(rx_data),
        .rx_overrun(rx_overrun), .frame_abort(frame_abort),
        .sclk(sclk), .cs_n(cs_n), .copi(copi), .cipo(cipo), .cipo_en(cipo_en)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_abort) n_abort++;
        if (rx_overrun)  n_ovr++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        pol;
        logic        pha;
        logic [5:0]  cfgw;
        int          w;
        logic [31:0] tx;
        logic [31:0] din;
        logic [31:0] exp_cap;
        logic [31:0] exp_rx;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic load_tx(input logic [31:0] v);
        @(negedge clk);
        tx_data = v;
        tx_load_req = 1'b1;
        #1;
        chk("tx_load_ack_idle", {31'd0, tx_load_ack}, 32'd1);
        @(negedge clk);
        tx_load_req = 1'b0;
    endtask

    task automatic ack_rx();
        @(negedge clk);
        rx_data_ack = 1'b1;
        @(negedge clk);
        rx_data_ack = 1'b0;
        chk("rx_req_after_ack", {31'd0, rx_data_req}, 32'd0);
    endtask

    // Controller model: sends nbits of d (MSB of an w-bit word first) and records cipo.
    task automatic spi_xfer(input logic pol, input logic pha, input logic [5:0] cfgw,
                            input int w, input logic [31:0] d, input int nbits,
                            input bit ack_last, output logic [31:0] cap);
        logic bitv;
        cap = '0;
        @(negedge clk);
        sclk = pol;
        cfg_cpol = pol;
        cfg_cpha = pha;
        cfg_width = cfgw;
        repeat (HALF) @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bitv = d[w-1-i];
            if (!pha) begin
                copi = bitv;
                repeat (HALF) @(negedge clk);
                cap = {cap[30:0], cipo};
                sclk = ~pol;
                if (ack_last && i == nbits - 1) begin
                    repeat (SYNC) @(negedge clk);
                    rx_data_ack = 1'b1;
                    @(negedge clk);
                    rx_data_ack = 1'b0;
                    repeat (HALF - SYNC - 1) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
                sclk = pol;
            end else begin
                sclk = ~pol;
                copi = bitv;
                repeat (HALF) @(negedge clk);
                cap = {cap[30:0], cipo};
                sclk = pol;
                repeat (HALF) @(negedge clk);
            end
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    initial begin
        logic [31:0] cap;
        int ab0, ov0, busy, found, prev_en_at_ack;

        vecs[0] = '{1'b0, 1'b0, 6'd16, 16, 32'h0000_A5C3, 32'h0000_1234, 32'h0000_A5C3, 32'h0000_1234};
        vecs[1] = '{1'b0, 1'b0, 6'd8,  8,  32'h0000_005A, 32'h0000_00C3, 32'h0000_005A, 32'h0000_00C3};
        vecs[2] = '{1'b0, 1'b1, 6'd8,  8,  32'h0000_005A, 32'h0000_00C3, 32'h0000_005A, 32'h0000_00C3};
        vecs[3] = '{1'b1, 1'b0, 6'd8,  8,  32'h0000_005A, 32'h0000_00C3, 32'h0000_005A, 32'h0000_00C3};
        vecs[4] = '{1'b1, 1'b1, 6'd8,  8,  32'h0000_005A, 32'h0000_00C3, 32'h0000_005A, 32'h0000_00C3};
        vecs[5] = '{1'b0, 1'b0, 6'd0,  32, 32'hDEAD_BEEF, 32'h1357_9BDF, 32'hDEAD_BEEF, 32'h1357_9BDF};
        vecs[6] = '{1'b1, 1'b1, 6'd1,  1,  32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
        vecs[7] = '{1'b1, 1'b0, 6'd40, 32, 32'h8000_0001, 32'hF0F0_F00F, 32'h8000_0001, 32'hF0F0_F00F};
        vecs[8] = '{1'b0, 1'b1, 6'd12, 12, 32'hFFFF_FABC, 32'h0000_05A5, 32'h0000_0ABC, 32'h0000_05A5};

        repeat (4) @(negedge clk);
        sync_rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cipo",        {31'd0, cipo},        32'd0);
        chk("rst_cipo_en",     {31'd0, cipo_en},     32'd0);
        chk("rst_tx_load_ack", {31'd0, tx_load_ack}, 32'd0);
        chk("rst_rx_data_req", {31'd0, rx_data_req}, 32'd0);
        chk("rst_rx_overrun",  {31'd0, rx_overrun},  32'd0);
        chk("rst_frame_abort", {31'd0, frame_abort}, 32'd0);
        chk("rst_rx_data",     rx_data,              32'd0);

        for (int i = 0; i < 9; i++) begin
            ab0 = n_abort;
            load_tx(vecs[i].tx);
            spi_xfer(vecs[i].pol, vecs[i].pha, vecs[i].cfgw, vecs[i].w, vecs[i].din,
                     vecs[i].w, 1'b0, cap);
            chk($sformatf("v%0d_cipo_word", i), cap, vecs[i].exp_cap);
            chk($sformatf("v%0d_rx_req", i), {31'd0, rx_data_req}, 32'd1);
            chk($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_rx);
            chk($sformatf("v%0d_no_abort", i), n_abort - ab0, 32'd0);
            ack_rx();
        end

        // Overrun: second frame arrives while the first is still unacknowledged.
        ov0 = n_ovr;
        spi_xfer(1'b0, 1'b0, 6'd8, 8, 32'h11, 8, 1'b0, cap);
        spi_xfer(1'b0, 1'b0, 6'd8, 8, 32'h22, 8, 1'b0, cap);
        chk("ovr_rx_data_kept", rx_data, 32'h11);
        chk("ovr_rx_req", {31'd0, rx_data_req}, 32'd1);
        chk("ovr_pulses", n_ovr - ov0, 32'd1);
        ack_rx();

        // Ack lands on the delivery cycle of the second frame.
        ov0 = n_ovr;
        spi_xfer(1'b0, 1'b0, 6'd8, 8, 32'h11, 8, 1'b0, cap);
        spi_xfer(1'b0, 1'b0, 6'd8, 8, 32'h22, 8, 1'b1, cap);
        chk("ackdlv_rx_data", rx_data, 32'h22);
        chk("ackdlv_rx_req", {31'd0, rx_data_req}, 32'd1);
        chk("ackdlv_no_overrun", n_ovr - ov0, 32'd0);
        ack_rx();

        // Abort after 5 of 16 bits.
        ab0 = n_abort;
        ov0 = n_ovr;
        spi_xfer(1'b0, 1'b0, 6'd16, 16, 32'hFFFF, 5, 1'b0, cap);
        chk("abort_pulses", n_abort - ab0, 32'd1);
        chk("abort_rx_data", rx_data, 32'h22);
        chk("abort_rx_req", {31'd0, rx_data_req}, 32'd0);
        chk("abort_idle", {31'd0, cipo_en}, 32'd0);
        chk("abort_no_overrun", n_ovr - ov0, 32'd0);

        // tx load requested mid-frame waits until the frame ends.
        load_tx(32'h1357);
        busy = 0;
        found = 0;
        prev_en_at_ack = 0;
        fork
            spi_xfer(1'b0, 1'b0, 6'd16, 16, 32'h0F0F, 16, 1'b0, cap);
            begin
                logic prev_en;
                repeat (100) @(negedge clk);
                tx_data = 32'hFFFF;
                tx_load_req = 1'b1;
                prev_en = cipo_en;
                for (int k = 0; k < 3000 && found == 0; k++) begin
                    @(negedge clk);
                    if (tx_load_ack && cipo_en) busy++;
                    if (tx_load_ack) begin
                        found = 1;
                        prev_en_at_ack = int'(prev_en);
                    end
                    prev_en = cipo_en;
                end
                @(negedge clk);
                tx_load_req = 1'b0;
            end
        join
        chk("txdefer_old_word", cap, 32'h1357);
        chk("txdefer_busy_ack", busy, 32'd0);
        chk("txdefer_acked", found, 32'd1);
        chk("txdefer_first_idle", prev_en_at_ack, 32'd1);
        chk("txdefer_rx_data", rx_data, 32'h0F0F);
        ack_rx();
        spi_xfer(1'b0, 1'b0, 6'd16, 16, 32'h00A5, 16, 1'b0, cap);
        chk("txdefer_new_word", cap, 32'hFFFF);
        chk("txdefer_rx2", rx_data, 32'h00A5);
        ack_rx();

        // Reset mid-frame with cs_n held low.
        ab0 = n_abort;
        fork
            spi_xfer(1'b0, 1'b0, 6'd16, 16, 32'hBEEF, 16, 1'b0, cap);
            begin
                repeat (2 * HALF + 6 * 2 * HALF + 5) @(negedge clk);
                sync_rst = 1'b1;
                @(negedge clk);
                chk("midrst_cipo", {31'd0, cipo}, 32'd0);
                chk("midrst_cipo_en", {31'd0, cipo_en}, 32'd0);
                chk("midrst_rx_req", {31'd0, rx_data_req}, 32'd0);
                chk("midrst_rx_data", rx_data, 32'd0);
                sync_rst = 1'b0;
            end
        join
        chk("midrst_no_delivery", {31'd0, rx_data_req}, 32'd0);
        chk("midrst_no_abort", n_abort - ab0, 32'd0);
        chk("midrst_rx_data_after", rx_data, 32'd0);
        spi_xfer(1'b0, 1'b0, 6'd16, 16, 32'h4321, 16, 1'b0, cap);
        chk("postrst_cipo_word", cap, 32'h0000);
        chk("postrst_rx_req", {31'd0, rx_data_req}, 32'd1);
        chk("postrst_rx_data", rx_data, 32'h4321);
        ack_rx();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_peripheral_generic.md
# spi_peripheral_generic

SPI peripheral (target) endpoint: the responder side of the same SPI link our controller drives. It oversamples `sclk`, `cs_n` and `copi` from an external controller in the local `clk` domain and supports all four CPOL/CPHA modes and frame widths from 1 to `Max_Bit_Width`. It shifts a preloaded response word out on `cipo` MSB-first and hands each fully received frame to local logic over a req/ack handshake. It sits between chip pins and a register-file or command-decoder client.

## Interface
- `Max_Bit_Width`, default 32: maximum frame width in bits.
- `Sync_Stages`, default 2: synchronizer depth on `sclk`, `cs_n` and `copi`; minimum 2.
- `Bit_Index_Width`, default `$clog2(Max_Bit_Width)+1`: derived; never overridden.
- `clk` in 1: single clock; all logic is in this domain.
- `clk_en` in 1: every register, including synchronizers, advances only when high.
- `sync_rst` in 1: reset, synchronous and active-high; takes priority over `clk_en`.
- `cfg_cpol`, `cfg_cpha` in 1 each: SPI mode, captured at frame start.
- `cfg_width` in Bit_Index_Width: bits per frame, captured at frame start; 0 or >Max clamps to Max.
- `tx_data` in Max_Bit_Width: response word, right-aligned; bit `width-1` is sent first.
- `tx_load_req` in 1 / `tx_load_ack` out 1: loads `tx_data` into the tx buffer.
- `rx_data_req` out 1 / `rx_data_ack` in 1: signals that a completed frame is waiting in `rx_data`.
- `rx_data` out Max_Bit_Width: last accepted frame, right-aligned, upper bits zero.
- `rx_overrun` out 1: one-cycle pulse when a frame was dropped.
- `frame_abort` out 1: one-cycle pulse when `cs_n` rises before `width` bits arrive.
- `sclk`, `cs_n`, `copi` in 1 each: asynchronous pins.
- `cipo` out 1, `cipo_en` out 1: data out and its output enable for the tristate.

## Operation
- Synchronizers: each pin passes through `Sync_Stages` flops. The chain reset values are `sclk`=0, `copi`=0 and `cs_n`=0 (asserted). Because `cs_n` resets to asserted, a `cs_n` held low through reset produces no falling edge, and the block never joins a frame mid-way.
- Edge classification uses the synchronized `sclk`, with `p` = previous value and `c` = current value.
  - Leading edge: `p==cpol && c!=cpol`.
  - Trailing edge: `p!=cpol && c==cpol`.
  - With cpha=0, data is sampled on the leading edge and driven on the trailing edge; with cpha=1 the roles swap.
- States:
  - IDLE: `cipo_en`=0 and `cipo`=0.
    - On a synchronized `cs_n` falling edge, capture the config, load the tx shift register from the tx buffer, clear the bit counter, and go to ACTIVE.
  - ACTIVE: `cipo_en`=1.
    - cpha=0: `cipo` presents bit `width-1` on ACTIVE entry and advances one bit on each trailing edge.
    - cpha=1: `cipo` advances one bit on each leading edge, with the first leading edge presenting bit `width-1`.
    - On each sample edge, shift the synchronized `copi` into the rx shift register LSB and increment the counter.
    - When the counter reaches `width`, deliver the frame (see handshake below) and go to COMPLETE.
    - If `cs_n` rises first, pulse `frame_abort`, discard the rx shift register, and go to IDLE.
  - COMPLETE: further `sclk` edges are ignored; `cipo` holds its last bit and `cipo_en`=1. Go to IDLE when `cs_n` rises.
- Tx handshake:
  - `tx_load_ack` = `tx_load_req && clk_en && state==IDLE`, combinational.
  - On ack, the tx buffer takes `tx_data` on the same edge.
  - In ACTIVE or COMPLETE, ack stays low and the request waits.
  - The buffer persists: an unreloaded buffer is retransmitted in the next frame.
- Rx handshake:
  - Delivery when `rx_data_req`=0: `rx_data` takes the zero-extended rx shift register and `rx_data_req` rises.
  - `rx_data_req` holds until `rx_data_ack && clk_en`, and `rx_data` is stable throughout.
  - Delivery while `rx_data_req`=1 and no ack: the new frame is dropped, `rx_overrun` pulses, and `rx_data` is unchanged.
  - Delivery and ack in the same cycle: the new frame loads, `rx_data_req` stays 1, and there is no overrun.
- Reset: state IDLE, tx buffer 0, shift registers 0, counter 0. A reset mid-frame drops the frame with no `frame_abort` pulse.

## Timing
- Latencies are counted in `clk_en` cycles.
- Pin to internal edge detect: `Sync_Stages`+1 cycles.
- `cs_n` fall to valid `cipo` (cpha=0): `Sync_Stages`+2 cycles.
- `cipo` update occurs `Sync_Stages`+2 cycles after the drive-edge pin transition.
- The controller's `sclk` half-period must be at least `Sync_Stages`+3 cycles; below that, behaviour is unspecified.
- `rx_data_req` rises the cycle after the final sample edge is detected.
- `frame_abort` and `rx_overrun` are high for exactly one `clk_en` cycle.
- Reset values of all outputs: `cipo`, `cipo_en`, `tx_load_ack`, `rx_data_req`, `rx_overrun` and `frame_abort` are 0; `rx_data` is 0.

## Test plan
- Mode 0, width 16, with `tx_data`=0x0000_A5C3 loaded in IDLE and the controller sending 0x1234 at divisor 20 -> controller captures 0xA5C3; `rx_data`=0x0000_1234; `rx_data_req` is 1 until ack.
- All four modes in sequence, width 8, with tx=0x5A and copi=0xC3 -> every frame returns 0x5A and `rx_data`=0x0000_00C3; no `frame_abort`.
- `cs_n` raised after 5 of 16 bits -> one `frame_abort` pulse; `rx_data` and `rx_data_req` unchanged; state IDLE.
- Two frames (0x11, then 0x22) with no ack -> `rx_data` stays 0x11 and `rx_overrun` pulses once. Repeat with ack landing on the second delivery cycle -> `rx_data`=0x22 and no overrun.
- `tx_load_req` asserted mid-frame with 0xFFFF -> `tx_load_ack` stays 0 until `cs_n` rises, then acks in the first IDLE cycle; the next frame sends 0xFFFF.
- `sync_rst` mid-frame with `cs_n` held low -> outputs reset. The remaining bits are ignored, with no delivery until a new `cs_n` high->low edge; the next full frame is received correctly.
